led_shift_driver: RTL and testbench

- Downstream consumer of the execute stage's 144-bit `led_commands` register (9 x 16-bit LED rows written by the `led` instruction).
- Snapshots the vector and serialises it MSB-first into an external chain of 74HC595-style shift registers: serial data, shift clock and storage latch.
- Sits between the processor and the board's LED array pins.
- Retransmits the vector whenever it changes, and also periodically to refresh the chain.

---
 rtl/led_shift_driver_pkg.sv | 14 +
 rtl/led_clk_divider.sv | 28 ++
 rtl/led_shift_driver.sv | 139 +++++++++++++
 tb/tb_led_shift_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_driver_pkg.sv
// Shared definitions for the LED shift-register driver: FSM encoding and LED array geometry.
package led_shift_driver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

    localparam int LED_ROWS  = 9;
    localparam int LED_ROW_W = 16;

endpackage

// File: rtl/led_clk_divider.sv
// Free-running divider: tick is high on every CLK_DIV-th cycle after a clear.
module led_clk_divider #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_shift_driver.sv
// Serialises the LED command vector MSB-first into a 74HC595-style chain, on change and on refresh.
// Optional PWM dimming on oe_n is built when LED_BRIGHTNESS_EN is defined.
module led_shift_driver
    import led_shift_driver_pkg::*;
#(
    parameter int NUM_BITS       = LED_ROWS * LED_ROW_W,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    input  logic [NUM_BITS-1:0] led_commands,
    input  logic [3:0]          brightness,
    output logic                ser_data,
    output logic                ser_clk,
    output logic                ser_latch,
    output logic                oe_n,
    output logic                busy,
    output logic                frame_done
);

    localparam int BIT_W = $clog2(NUM_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_e              state;
    logic [NUM_BITS-1:0] snapshot;
    logic [NUM_BITS-1:0] shadow;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    refresh_cnt;
    logic                tick;
    logic                div_clear;
    logic                start;

    // Divider is held at zero while idle so every frame starts phase-aligned.
    assign div_clear = (state == IDLE);

    led_clk_divider #(
        .CLK_DIV(CLK_DIV),
        .CNT_W  (CNT_W)
    ) u_div (
        .clk  (clock),
        .rst_n(resetn),
        .clear(div_clear),
        .tick (tick)
    );

    assign start = enable && ((led_commands != snapshot) || (refresh_cnt == REFRESH_LAST));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ser_data    <= 1'b0;
            ser_clk     <= 1'b0;
            ser_latch   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            snapshot    <= '0;
            shadow      <= '0;
            bit_cnt     <= '0;
            refresh_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow      <= led_commands;
                        snapshot    <= led_commands;
                        refresh_cnt <= '0;
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        ser_data    <= led_commands[NUM_BITS-1];
                        state       <= SHIFT_LO;
                    end else if (enable || (refresh_cnt != REFRESH_LAST)) begin
                        refresh_cnt <= refresh_cnt + CNT_W'(1);
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        ser_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        ser_clk <= 1'b0;
                        shadow  <= shadow << 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            ser_data <= shadow[NUM_BITS-2];
                            state    <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        ser_latch  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LED_BRIGHTNESS_EN
    logic [3:0] pwm_cnt;
    logic [3:0] pwm_next;
    logic       latch_next;

    assign pwm_next   = pwm_cnt + 4'd1;
    // Mirrors the next value of ser_latch so oe_n blanks in the same cycles.
    assign latch_next = (state == LATCH) ? !tick
                      : ((state == SHIFT_HI) && tick && (bit_cnt == LAST_BIT));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= 4'd0;
            oe_n    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_next;
            oe_n    <= latch_next || (pwm_next >= brightness);
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign oe_n = 1'b0;
`endif

endmodule

// File: tb/tb_led_shift_driver.sv
// Self-checking bench for led_shift_driver: random LED images, scoreboard of expected frames.
`timescale 1ns/1ps
module tb_led_shift_driver;

    localparam int NB        = 144;
    localparam int CLK_DIV   = 4;
    localparam int REFRESH   = 128;
    localparam int FRAME_LEN = 1 + NB * 2 * CLK_DIV + CLK_DIV;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b1;
    logic [NB-1:0] led_commands = '0;
    logic [3:0]    brightness = 4'd0;
    logic          ser_data, ser_clk, ser_latch, oe_n, busy, frame_done;

    always #5 clock = ~clock;

    led_shift_driver #(
        .NUM_BITS      (NB),
        .CLK_DIV       (CLK_DIV),
        .REFRESH_CYCLES(REFRESH),
        .CNT_W         (20)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .led_commands(led_commands),
        .brightness  (brightness),
        .ser_data    (ser_data),
        .ser_clk     (ser_clk),
        .ser_latch   (ser_latch),
        .oe_n        (oe_n),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int total = 0;
    int bad   = 0;
    logic [NB-1:0] exp_q[$];
    int            exp_t_q[$];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a frame is an opaque busy interval of FRAME_LEN-1 cycles after its start cycle.
    int            cyc = 0;
    int            busy_left = 0;
    int            idle_cnt = 0;
    logic [NB-1:0] last_sent = '0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            if (busy_left > 0) begin
                void'(exp_q.pop_back());
                void'(exp_t_q.pop_back());
            end
            busy_left = 0;
            idle_cnt  = 0;
            last_sent = '0;
        end else begin
            cyc++;
            if (busy_left > 0) begin
                busy_left--;
            end else if (enable && (led_commands != last_sent || idle_cnt == REFRESH - 1)) begin
                exp_q.push_back(led_commands);
                exp_t_q.push_back(cyc);
                last_sent = led_commands;
                idle_cnt  = 0;
                busy_left = FRAME_LEN - 1;
            end else if (enable || idle_cnt < REFRESH - 1) begin
                idle_cnt++;
            end
        end
    end

    // Chain model and frame monitor.
    logic [NB-1:0] chain = '0;
    logic [15:0]   first16 = '0;
    int            edges = 0, latch_w = 0, busy_w = 0;
    logic          prev_clk = 1'b0;

    always @(negedge clock) begin
        if (!resetn) begin
            edges = 0; latch_w = 0; busy_w = 0; prev_clk = 1'b0;
        end else begin
            if (ser_clk && !prev_clk) begin
                chain = {chain[NB-2:0], ser_data};
                if (edges < 16) first16 = {first16[14:0], ser_data};
                edges++;
            end
            prev_clk = ser_clk;
            if (ser_latch) latch_w++;
            if (busy) busy_w++;
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got frame_done at cycle %0d, expected none", cyc);
                end else begin
                    logic [NB-1:0] ev;
                    int            et;
                    ev = exp_q.pop_front();
                    et = exp_t_q.pop_front();
                    check("frame_data", chain, ev);
                    check("first16", NB'(first16), NB'(ev[NB-1 -: 16]));
                    check("clk_edges", NB'(edges), NB'(NB));
                    check("latch_width", NB'(latch_w), NB'(CLK_DIV));
                    check("busy_len", NB'(busy_w), NB'(FRAME_LEN - 1));
                    check("done_cycle", NB'(cyc), NB'(et + FRAME_LEN - 1));
                    check("done_pins", NB'({ser_clk, ser_latch, ser_data, oe_n, busy}), '0);
                end
                edges = 0; latch_w = 0; busy_w = 0;
            end
        end
    end

    function automatic logic [NB-1:0] rand_vec();
        logic [NB-1:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | NB'($urandom());
        return v;
    endfunction

    task automatic drive(input logic [NB-1:0] v);
        @(negedge clock);
        led_commands = v;
    endtask

    task automatic run_until_quiet(input string name, input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clock);
        while ((busy || busy_left > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, NB'(n >= budget), '0);
    endtask

    task automatic wait_sig(input string name, input int which, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clock);
            if ((which == 0 && busy) || (which == 1 && frame_done) || (which == 2 && ser_clk)) break;
            n++;
        end
        check(name, NB'(n >= budget), '0);
    endtask

    initial begin
        logic [NB-1:0] v;
        int            seen;

        repeat (3) @(negedge clock);
        check("reset_pins", NB'({ser_data, ser_clk, ser_latch, oe_n, busy, frame_done}), '0);
        resetn = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy) seen++;
        end
        check("no_start_after_reset", NB'(seen), '0);
        check("idle_pins", NB'({ser_data, ser_clk, ser_latch, oe_n, busy, frame_done}), '0);

        drive(NB'(1));
        run_until_quiet("single_frame", 4 * FRAME_LEN);

        v = '0;
        v[NB-1 -: 16] = 16'hA5A5;
        drive(v);
        run_until_quiet("pattern_frame", 4 * FRAME_LEN);

        for (int i = 0; i < 4; i++) begin
            drive(rand_vec());
            run_until_quiet("random_frame", 4 * FRAME_LEN);
        end

        v = rand_vec();
        v[15:0] = 16'h0000;
        drive(v);
        wait_sig("midchange_start", 0, 10);
        repeat (300) @(negedge clock);
        v[15:0] = 16'hFFFF;
        led_commands = v;
        run_until_quiet("midchange_frames", 4 * FRAME_LEN);

        repeat (2 * (FRAME_LEN + REFRESH) + 50) @(negedge clock);
        run_until_quiet("refresh_frames", 4 * FRAME_LEN);

        enable = 1'b0;
        seen = 0;
        repeat (3 * REFRESH) begin
            @(negedge clock);
            if (busy) seen++;
        end
        check("no_start_disabled", NB'(seen), '0);
        enable = 1'b1;
        @(negedge clock);
        check("reenable_immediate", NB'(busy), NB'(1));
        run_until_quiet("reenable_frame", 4 * FRAME_LEN);

        drive(rand_vec());
        wait_sig("disable_mid_start", 0, 10);
        repeat (200) @(negedge clock);
        enable = 1'b0;
        repeat (FRAME_LEN + 50) @(negedge clock);
        check("disable_mid_idle", NB'(busy), '0);
        enable = 1'b1;
        run_until_quiet("disable_mid_frames", 4 * FRAME_LEN);

        drive(rand_vec());
        wait_sig("simul_done", 1, 4 * FRAME_LEN);
        repeat (REFRESH - 1) @(negedge clock);
        led_commands = rand_vec();
        run_until_quiet("simul_frames", 4 * FRAME_LEN);

        v = rand_vec();
        v[NB-1] = 1'b1;
        drive(v);
        wait_sig("reset_mid_hi", 2, 100);
        #2 resetn = 1'b0;
        #1 check("reset_mid_pins", NB'({ser_data, ser_clk, ser_latch, oe_n, busy, frame_done}), '0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        run_until_quiet("after_reset_frame", 4 * FRAME_LEN);

        check("queue_empty", NB'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        bad++;
        $display("FAIL watchdog: got no completion, expected finish before 5ms");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
